// File: rtl/jt1943_sdram_arb.sv
// jt1943_sdram_arb: read-slot arbiter sharing the single SDRAM read port
// between the ROM requesters (0 = main CPU, 1..N-1 = char/map/scr/obj).
// Requester 0 has fixed priority, 1..N-1 share round-robin, and a per-requester
// wait counter forces a grant after MAXWAIT lost arbitrations.
//
// Optional feature: define JT1943_ARB_WDOG_EN to add a transaction watchdog
// that aborts a read stuck in ISSUE/WAIT for WDOG cycles and pulses err.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cen             arbitration enable (12 MHz strobe)
//   req   [N]       level-sensitive pending request per requester
//   addr  [N*AW]    flat address bus, requester i at [i*AW +: AW]
//   sdram_addr      address of the granted request
//   sdram_req       read request to the SDRAM controller
//   sdram_ack       controller accepted the request (pulse)
//   data_rdy        read data valid (pulse)
//   grant [N]       one-hot owner of the current transaction
//   we    [N]       one-hot write strobe to the owner's cache
//   busy            state machine not idle
//   err             watchdog abort pulse (0 unless JT1943_ARB_WDOG_EN)
module jt1943_sdram_arb #(
  parameter int unsigned N       = 7,
  parameter int unsigned AW      = 22,
  parameter logic [3:0]  MAXWAIT = 4'd12,
  parameter logic [5:0]  WDOG    = 6'd63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] addr,
  output logic [AW-1:0]   sdram_addr,
  output logic            sdram_req,
  input  logic            sdram_ack,
  input  logic            data_rdy,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    we,
  output logic            busy,
  output logic            err
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    we_q, we_d;
  logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic            sdram_req_q, sdram_req_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   last_rr_q, last_rr_d;
  logic [CW-1:0]   wait_cnt_q [N];
  logic [CW-1:0]   wait_cnt_d [N];

  logic            arb_c;
  logic [IW-1:0]   win_idx_c;
  logic [AW-1:0]   win_addr_c;
  logic            starve_hit_c;
  logic [IW-1:0]   starve_idx_c;
  logic            rr_hit_c;
  logic [IW-1:0]   rr_idx_c;

`ifdef JT1943_ARB_WDOG_EN
  logic [5:0]      wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            wdog_hit_c;
`endif

  // Winner selection: starved (lowest index) > requester 0 > round-robin 1..N-1
  always_comb begin
    starve_hit_c = 1'b0;
    starve_idx_c = '0;
    rr_hit_c     = 1'b0;
    rr_idx_c     = '0;
    win_addr_c   = '0;
    arb_c        = (state_q == ST_IDLE) && cen && (|req);
    // Descending scan leaves the lowest starved index
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i] && (wait_cnt_q[i] == MAXWAIT)) begin
        starve_hit_c = 1'b1;
        starve_idx_c = IW'(i);
      end
    end
    // Descending k leaves the first requester found after last_rr
    for (int k = int'(N) - 1; k >= 1; k--) begin
      int c;
      c = ((int'(last_rr_q) - 1 + k) % (int'(N) - 1)) + 1;
      if (req[c]) begin
        rr_hit_c = 1'b1;
        rr_idx_c = IW'(c);
      end
    end
    if (starve_hit_c)  win_idx_c = starve_idx_c;
    else if (req[0])   win_idx_c = '0;
    else               win_idx_c = rr_idx_c;
    for (int i = 0; i < int'(N); i++) begin
      if (win_idx_c == IW'(i)) win_addr_c = addr[i*int'(AW) +: AW];
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = '0;
    sdram_addr_d = sdram_addr_q;
    sdram_req_d  = sdram_req_q;
    last_rr_d    = last_rr_q;
    wait_cnt_d   = wait_cnt_q;
`ifdef JT1943_ARB_WDOG_EN
    err_d        = 1'b0;
    wdog_hit_c   = (state_q != ST_IDLE) && (wdog_q == WDOG - 6'd1);
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (arb_c) begin
          state_d      = ST_ISSUE;
          grant_d      = N'(1) << win_idx_c;
          sdram_addr_d = win_addr_c;
          sdram_req_d  = 1'b1;
          if (win_idx_c != '0) last_rr_d = win_idx_c;
        end
      end
      ST_ISSUE: begin
        // A data_rdy coinciding with the ack belongs to an older read
        if (sdram_ack) begin
          state_d     = ST_WAIT;
          sdram_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          state_d = ST_IDLE;
          we_d    = grant_q;
          grant_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        sdram_req_d = 1'b0;
      end
    endcase

    // Wait counters: count lost arbitrations, clear on win or idle request
    for (int i = 0; i < int'(N); i++) begin
      if (!req[i]) begin
        wait_cnt_d[i] = '0;
      end else if (arb_c) begin
        if (win_idx_c == IW'(i))              wait_cnt_d[i] = '0;
        else if (wait_cnt_q[i] != MAXWAIT)    wait_cnt_d[i] = wait_cnt_q[i] + CW'(1);
      end
    end

`ifdef JT1943_ARB_WDOG_EN
    // Abort a stuck read; the owner is charged one lost arbitration
    if (wdog_hit_c) begin
      state_d     = ST_IDLE;
      grant_d     = '0;
      we_d        = '0;
      sdram_req_d = 1'b0;
      err_d       = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        if (grant_q[i] && req[i] && (wait_cnt_q[i] != MAXWAIT))
          wait_cnt_d[i] = wait_cnt_q[i] + CW'(1);
      end
    end
    wdog_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? 6'd0 : wdog_q + 6'd1;
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      we_q         <= '0;
      sdram_addr_q <= '0;
      sdram_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      last_rr_q    <= IW'(N - 1);
      for (int i = 0; i < int'(N); i++) wait_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_req_q  <= sdram_req_d;
      busy_q       <= busy_d;
      last_rr_q    <= last_rr_d;
      for (int i = 0; i < int'(N); i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

`ifdef JT1943_ARB_WDOG_EN
  // Watchdog counter and abort flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant      = grant_q;
  assign we         = we_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_req  = sdram_req_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_jt1943_sdram_arb.sv
// Testbench for jt1943_sdram_arb: per-cycle vector table for the basic
// handshake, plus sequences for priority/starvation, round-robin,
// request withdrawal, reset mid-transaction and (optionally) the watchdog.
module tb_jt1943_sdram_arb;

  localparam int unsigned N  = 7;
  localparam int unsigned AW = 22;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cen = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_req;
  logic            sdram_ack = 1'b0;
  logic            data_rdy = 1'b0;
  logic [N-1:0]    grant;
  logic [N-1:0]    we;
  logic            busy;
  logic            err;

  int total = 0;
  int bad   = 0;

  jt1943_sdram_arb #(.N(N), .AW(AW), .MAXWAIT(4'd12), .WDOG(6'd63)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .req        (req),
    .addr       (addr),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .grant      (grant),
    .we         (we),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cen;
    logic [N-1:0]  req;
    logic          ack;
    logic          rdy;
    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_we;
    logic          e_sreq;
    logic          e_busy;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic logic [AW-1:0] addr_of(input int i);
    if (i == 2) return 22'h1C_010;
    return 22'h20_0000 + AW'(i * 32'h111);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; cen = 1'b0; sdram_ack = 1'b0; data_rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // One full read: wait for the grant, ack after ad cycles, rdy after rd more
  task automatic txn(input logic [N-1:0] r, input int ad, input int rd, output logic [N-1:0] g);
    int n;
    req = r; cen = 1'b1; sdram_ack = 1'b0; data_rdy = 1'b0;
    n = 0;
    while (!sdram_req && n < 20) begin step(); n++; end
    chk("txn_req_seen", 32'(sdram_req), 32'd1);
    g = grant;
    for (int i = 0; i < int'(N); i++)
      if (g[i]) chk("txn_addr", 32'(sdram_addr), 32'(addr_of(i)));
    repeat (ad) step();
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    chk("txn_ack_busy_sreq", 32'({busy, sdram_req}), 32'(2'b10));
    repeat (rd) step();
    data_rdy = 1'b1; step(); data_rdy = 1'b0;
    chk("txn_we", 32'(we), 32'(g));
    chk("txn_grant_clr", 32'(grant), 32'd0);
  endtask

  vec_t vt [18];
  logic [N-1:0] g;
  logic [N-1:0] exp_g;

  initial begin
    for (int i = 0; i < int'(N); i++) addr[i*int'(AW) +: AW] = addr_of(i);

    //        cen   req          ack   rdy   e_grant      e_we         sreq  busy  e_addr
    vt[0]  = '{1'b0, 7'b0000100, 1'b0, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 22'h0};
    vt[1]  = '{1'b1, 7'b0000100, 1'b0, 1'b0, 7'b0000100, 7'b0000000, 1'b1, 1'b1, 22'h1C_010};
    vt[2]  = '{1'b1, 7'b0000100, 1'b0, 1'b0, 7'b0000100, 7'b0000000, 1'b1, 1'b1, 22'h1C_010};
    vt[3]  = '{1'b1, 7'b0000100, 1'b0, 1'b1, 7'b0000100, 7'b0000000, 1'b1, 1'b1, 22'h1C_010};
    vt[4]  = '{1'b1, 7'b0000100, 1'b1, 1'b0, 7'b0000100, 7'b0000000, 1'b0, 1'b1, 22'h1C_010};
    vt[5]  = '{1'b1, 7'b0000100, 1'b0, 1'b0, 7'b0000100, 7'b0000000, 1'b0, 1'b1, 22'h1C_010};
    vt[6]  = '{1'b1, 7'b0000100, 1'b0, 1'b0, 7'b0000100, 7'b0000000, 1'b0, 1'b1, 22'h1C_010};
    vt[7]  = '{1'b1, 7'b0000000, 1'b0, 1'b0, 7'b0000100, 7'b0000000, 1'b0, 1'b1, 22'h1C_010};
    vt[8]  = '{1'b1, 7'b0000000, 1'b0, 1'b1, 7'b0000000, 7'b0000100, 1'b0, 1'b0, 22'h0};
    vt[9]  = '{1'b1, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 22'h0};
    vt[10] = '{1'b1, 7'b0000010, 1'b0, 1'b0, 7'b0000010, 7'b0000000, 1'b1, 1'b1, addr_of(1)};
    vt[11] = '{1'b1, 7'b0000010, 1'b1, 1'b1, 7'b0000010, 7'b0000000, 1'b0, 1'b1, addr_of(1)};
    vt[12] = '{1'b1, 7'b0000000, 1'b0, 1'b1, 7'b0000000, 7'b0000010, 1'b0, 1'b0, 22'h0};
    vt[13] = '{1'b1, 7'b0000000, 1'b1, 1'b1, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 22'h0};
    vt[14] = '{1'b0, 7'b1000000, 1'b0, 1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 22'h0};
    vt[15] = '{1'b1, 7'b1000000, 1'b0, 1'b0, 7'b1000000, 7'b0000000, 1'b1, 1'b1, addr_of(6)};
    vt[16] = '{1'b1, 7'b1000000, 1'b1, 1'b0, 7'b1000000, 7'b0000000, 1'b0, 1'b1, addr_of(6)};
    vt[17] = '{1'b1, 7'b0000000, 1'b0, 1'b1, 7'b0000000, 7'b1000000, 1'b0, 1'b0, 22'h0};

    // Reset state
    step(); step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_sreq_busy_err", 32'({sdram_req, busy, err}), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    rst = 1'b0;

    // Vector table
    for (int v = 0; v < 18; v++) begin
      cen = vt[v].cen; req = vt[v].req; sdram_ack = vt[v].ack; data_rdy = vt[v].rdy;
      step();
      chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vt[v].e_grant));
      chk($sformatf("vec%0d_we", v), 32'(we), 32'(vt[v].e_we));
      chk($sformatf("vec%0d_sreq", v), 32'(sdram_req), 32'(vt[v].e_sreq));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].e_busy));
      if (vt[v].e_grant != '0)
        chk($sformatf("vec%0d_addr", v), 32'(sdram_addr), 32'(vt[v].e_addr));
    end

    // Round-robin over 1..6
    reset_dut();
    for (int t = 0; t < 7; t++) begin
      txn(7'b1111110, 0, 0, g);
      exp_g = 7'b0000001 << ((t % 6) + 1);
      chk($sformatf("rr%0d", t), 32'(g), 32'(exp_g));
    end

    // Fixed priority with starvation guard
    reset_dut();
    for (int t = 0; t < 19; t++) begin
      txn(7'b1111111, 0, 0, g);
      if (t < 12)      exp_g = 7'b0000001;
      else if (t < 18) exp_g = 7'b0000001 << (t - 11);
      else             exp_g = 7'b0000001;
      chk($sformatf("prio%0d", t), 32'(g), 32'(exp_g));
    end

    // Request withdrawal during ISSUE
    reset_dut();
    req = 7'b0001000; cen = 1'b1;
    step();
    chk("wd_grant", 32'(grant), 32'(7'b0001000));
    req = '0;
    step();
    chk("wd_hold", 32'({grant, sdram_req}), 32'({7'b0001000, 1'b1}));
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    step();
    data_rdy = 1'b1; step(); data_rdy = 1'b0;
    chk("wd_we", 32'(we), 32'(7'b0001000));
    chk("wd_wait_cnt3", 32'(dut.wait_cnt_q[3]), 32'd0);
    step();
    chk("wd_idle", 32'({busy, we}), 32'd0);

    // Reset while in WAIT
    reset_dut();
    txn(7'b1111110, 0, 0, g);
    txn(7'b1111110, 0, 0, g);
    step();
    chk("rw_grant3", 32'(grant), 32'(7'b0001000));
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    chk("rw_in_wait", 32'({busy, sdram_req}), 32'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("rw_async_out", 32'({grant, we, sdram_req, busy}), 32'd0);
    data_rdy = 1'b1;
    step();
    chk("rw_no_we0", 32'(we), 32'd0);
    step();
    chk("rw_no_we1", 32'(we), 32'd0);
    rst = 1'b0; data_rdy = 1'b0;
    step();
    chk("rw_next_grant", 32'(grant), 32'(7'b0000010));
    chk("rw_next_we", 32'(we), 32'd0);

`ifdef JT1943_ARB_WDOG_EN
    // Watchdog: never acknowledge
    begin
      int n;
      reset_dut();
      req = 7'b0000100; cen = 1'b1;
      step();
      chk("wdog_issue", 32'(sdram_req), 32'd1);
      n = 0;
      while (!err && n < 100) begin step(); n++; end
      chk("wdog_cycles", 32'(n), 32'd63);
      chk("wdog_abort", 32'({grant, we, sdram_req, busy}), 32'd0);
      req = '0;
      step();
      chk("wdog_err_pulse", 32'(err), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
